// File: rtl/ones_pkg.sv
// Shared definitions for the ones-count pipeline (CountOnes and ones_frame_accum).
// Holds the per-byte ones-count width, the clamp level, the accumulator
// state encoding and the clamp helper.
package ones_pkg;

    // Width of a per-byte ones count and the largest legal count for a byte.
    localparam int ONES_W   = 5;
    localparam int MAX_ONES = 8;

    typedef enum logic [1:0] {
        RESET_WAIT = 2'd0,
        ACCUM      = 2'd1,
        HOLD       = 2'd2
    } accum_state_e;

    // A byte cannot hold more than 8 ones; anything above that is clamped to 8.
    function automatic logic [ONES_W-1:0] sat_ones(input logic [ONES_W-1:0] ones);
        return (ones > ONES_W'(MAX_ONES)) ? ONES_W'(MAX_ONES) : ones;
    endfunction

endpackage

// File: rtl/ones_frame_accum.sv
// ones_frame_accum: sums per-byte ones counts over a frame of up to FRAME_LEN
// bytes and presents the total and byte count on a valid/ready output.
// Optional feature macro: ONES_ACCUM_THRESH_EN adds the thresh input and the
// registered out_over flag (frame total strictly greater than thresh).
module ones_frame_accum
    import ones_pkg::*;
#(
    parameter int FRAME_LEN = 16,
    parameter int SUM_W     = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ONES_W-1:0] in_ones,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SUM_W-1:0]  out_sum,
    output logic [7:0]        out_count
`ifdef ONES_ACCUM_THRESH_EN
    ,
    input  logic [SUM_W-1:0]  thresh,
    output logic              out_over
`endif
);

    accum_state_e     state_q, state_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [SUM_W-1:0] out_sum_q, out_sum_d;
    logic [7:0]       out_count_q, out_count_d;
    logic             in_ready_q;
    logic             out_valid_q;

    logic             xfer;
    logic             close;
    logic [SUM_W-1:0] acc_sum;
    logic [7:0]       cnt_inc;

    assign xfer    = in_valid && in_ready_q;
    assign acc_sum = acc_q + SUM_W'(sat_ones(in_ones));
    assign cnt_inc = cnt_q + 8'd1;
    // A byte that fills the frame and also carries in_last is still one close.
    assign close   = xfer && ((cnt_inc == 8'(FRAME_LEN)) || in_last);

    // Next-state logic: leave reset wait on the first edge, close into HOLD,
    // return to ACCUM once the consumer takes the result.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RESET_WAIT: state_d = ACCUM;
            ACCUM:      if (close) state_d = HOLD;
            HOLD:       if (out_valid_q && out_ready) state_d = ACCUM;
            default:    state_d = RESET_WAIT;
        endcase
    end

    // Accumulator and result capture; the closing byte goes straight into the result.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        if (xfer) begin
            if (close) begin
                acc_d       = '0;
                cnt_d       = '0;
                out_sum_d   = acc_sum;
                out_count_d = cnt_inc;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_inc;
            end
        end
    end

    // State, datapath and handshake flops; handshakes are decoded from the next state
    // so every output comes straight from a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RESET_WAIT;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            in_ready_q  <= (state_d == ACCUM);
            out_valid_q <= (state_d == HOLD);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;

`ifdef ONES_ACCUM_THRESH_EN
    logic over_q;

    // Threshold flag is sampled with the result and held alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            over_q <= 1'b0;
        end else if (close) begin
            over_q <= (acc_sum > thresh);
        end
    end

    assign out_over = over_q;
`endif

endmodule
